// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter with next-PC selection and a circular
//   return-address stack (RAS).
//
//   Parameters
//     PC_WIDTH     width of the PC and all address ports
//     PC_INIT      value loaded into pc_out on reset
//     INSTR_BYTES  sequential increment (power of two); loaded PCs are aligned to it
//     RAS_DEPTH    number of RAS entries (power of two, >= 2)
//
//   Ports
//     CLK            clock, all state changes on the rising edge
//     RST            synchronous active-high reset
//     pcWEN          advance enable (low = stall)
//     next_sel       0 SEQ, 1 TARGET, 2 RETURN, 3 behaves as SEQ
//     target         next PC for TARGET
//     link           push pc_plus onto the RAS on this advance
//     redirect       highest-priority PC load from later stages
//     redirect_pc    PC loaded on redirect
//     ras_clear      empty the RAS (count and pointer to 0)
//     pc_out         current fetch PC (registered)
//     pc_plus        pc_out + INSTR_BYTES (combinational, wraps)
//     ras_top        top RAS entry, 0 when empty
//     ras_count      number of valid RAS entries
//     ras_underflow  one-cycle pulse after a RETURN on an empty RAS
module pc_sequencer #(
  parameter int                     PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    PC_INIT     = '0,
  parameter int                     INSTR_BYTES = 4,
  parameter int                     RAS_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          pcWEN,
  input  logic [1:0]                    next_sel,
  input  logic [PC_WIDTH-1:0]           target,
  input  logic                          link,
  input  logic                          redirect,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  input  logic                          ras_clear,
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic [PC_WIDTH-1:0]           pc_plus,
  output logic [PC_WIDTH-1:0]           ras_top,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SEL_TARGET = 2'd1;
  localparam logic [1:0] SEL_RETURN = 2'd2;

  // Clearing the low bits of a loaded PC; a zero mask term when INSTR_BYTES=1.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INSTR_BYTES - 1));
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;      // next free slot; top is ptr-1
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                underflow_reg, underflow_next;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic                ras_we;
  logic [PTR_W-1:0]    ras_waddr;
  logic [PTR_W-1:0]    top_idx;
  logic                ras_empty;
  logic                ret_hit;

  assign top_idx   = ptr_reg - PTR_W'(1);
  assign ras_empty = (count_reg == '0);

  assign pc_out        = pc_reg;
  assign pc_plus       = pc_reg + PC_INC;
  assign ras_top       = ras_empty ? '0 : ras_mem[top_idx];
  assign ras_count     = count_reg;
  assign ras_underflow = underflow_reg;

  // A RETURN that actually consumes a RAS entry on this advance.
  assign ret_hit = pcWEN && !redirect && (next_sel == SEL_RETURN) && !ras_empty;

  always_comb begin
    pc_next        = pc_reg;
    ptr_next       = ptr_reg;
    count_next     = count_reg;
    underflow_next = 1'b0;
    ras_we         = 1'b0;
    ras_waddr      = ptr_reg;

    if (redirect) begin
      pc_next = redirect_pc & ALIGN_MASK;
    end else if (pcWEN) begin
      case (next_sel)
        SEL_TARGET: pc_next = target & ALIGN_MASK;
        SEL_RETURN: begin
          if (!ras_empty) begin
            pc_next = ras_top;
          end else begin
            pc_next        = pc_plus;
            underflow_next = 1'b1;
          end
        end
        default:    pc_next = pc_plus;
      endcase

      if (link && ret_hit) begin
        // Pop and push cancel: the top entry is replaced in place.
        ras_we    = 1'b1;
        ras_waddr = top_idx;
      end else if (link) begin
        // A full stack wraps the pointer and silently overwrites the oldest entry.
        ras_we     = 1'b1;
        ras_waddr  = ptr_reg;
        ptr_next   = ptr_reg + PTR_W'(1);
        count_next = (count_reg == CNT_FULL) ? CNT_FULL : count_reg + CNT_W'(1);
      end else if (ret_hit) begin
        ptr_next   = top_idx;
        count_next = count_reg - CNT_W'(1);
      end
    end

    // Clear overrides any push or pop in the same cycle.
    if (ras_clear) begin
      ras_we     = 1'b0;
      ptr_next   = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg        <= PC_INIT;
      ptr_reg       <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      pc_reg        <= pc_next;
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
      if (ras_we) begin
        ras_mem[ras_waddr] <= pc_plus;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pcWEN;
  logic [1:0]  next_sel;
  logic [31:0] target;
  logic        link;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ras_clear;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] SEQ = 2'd0, TGT = 2'd1, RET = 2'd2, RSV = 2'd3;

  pc_sequencer dut (
    .CLK(CLK), .RST(RST), .pcWEN(pcWEN), .next_sel(next_sel), .target(target),
    .link(link), .redirect(redirect), .redirect_pc(redirect_pc), .ras_clear(ras_clear),
    .pc_out(pc_out), .pc_plus(pc_plus), .ras_top(ras_top), .ras_count(ras_count),
    .ras_underflow(ras_underflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Drive one cycle's inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic apply(input logic wen, input logic [1:0] sel, input logic [31:0] tgt,
                       input logic lnk, input logic rd, input logic [31:0] rdpc,
                       input logic clr);
    pcWEN = wen; next_sel = sel; target = tgt; link = lnk;
    redirect = rd; redirect_pc = rdpc; ras_clear = clr;
    @(posedge CLK); #1;
    $display("t=%0t wen=%0b sel=%0d lnk=%0b rd=%0b clr=%0b -> pc=%h top=%h cnt=%0d uf=%0b",
             $time, wen, sel, lnk, rd, clr, pc_out, ras_top, ras_count, ras_underflow);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    apply(1'b0, SEQ, 32'h0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic test_reset;
    logic [31:0] exp_pc;
    RST = 1'b1;
    apply(1'b0, SEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    RST = 1'b0;
    vectors++;
    if (pc_out !== 32'h0 || ras_count !== 3'd0 || ras_top !== 32'h0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pc=%h cnt=%0d top=%h uf=%0b, required pc=0 cnt=0 top=0 uf=0",
               pc_out, ras_count, ras_top, ras_underflow);
    end
    vectors++;
    if (pc_plus !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_pc_plus: got %h, required 00000004", pc_plus);
    end
    // Four sequential advances; the last one uses the reserved selector.
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, (i == 4) ? RSV : SEQ, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      exp_pc = 32'(i * 4);
      vectors++;
      if (pc_out !== exp_pc || ras_count !== 3'd0) begin
        miscompares++;
        $display("FAIL seq_%0d: pc=%h cnt=%0d, required pc=%h cnt=0", i, pc_out, ras_count, exp_pc);
      end
    end
  endtask

  task automatic test_stall_redirect;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, TGT, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (pc_out !== 32'h10 || ras_count !== 3'd0) begin
        miscompares++;
        $display("FAIL stall_%0d: pc=%h cnt=%0d, required pc=00000010 cnt=0", i, pc_out, ras_count);
      end
    end
    redirect_to(32'h203);
    vectors++;
    if (pc_out !== 32'h200) begin
      miscompares++;
      $display("FAIL redirect_align: got %h, required 00000200", pc_out);
    end
  endtask

  task automatic test_call_return;
    redirect_to(32'h100);
    apply(1'b1, TGT, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h400 || ras_top !== 32'h104 || ras_count !== 3'd1) begin
      miscompares++;
      $display("FAIL call: pc=%h top=%h cnt=%0d, required pc=00000400 top=00000104 cnt=1",
               pc_out, ras_top, ras_count);
    end
    apply(1'b1, RET, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h104 || ras_count !== 3'd0 || ras_top !== 32'h0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL return: pc=%h cnt=%0d top=%h uf=%0b, required pc=00000104 cnt=0 top=0 uf=0",
               pc_out, ras_count, ras_top, ras_underflow);
    end
  endtask

  task automatic test_ras_overflow;
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h44; exp_ret[1] = 32'h34; exp_ret[2] = 32'h24; exp_ret[3] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      redirect_to(32'(i * 16));
      apply(1'b1, TGT, 32'h1003, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    vectors++;
    if (pc_out !== 32'h1000 || ras_count !== 3'd4 || ras_top !== 32'h44) begin
      miscompares++;
      $display("FAIL overflow_full: pc=%h cnt=%0d top=%h, required pc=00001000 cnt=4 top=00000044",
               pc_out, ras_count, ras_top);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, RET, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (pc_out !== exp_ret[i] || ras_count !== 3'(3 - i) || ras_underflow !== 1'b0) begin
        miscompares++;
        $display("FAIL overflow_ret_%0d: pc=%h cnt=%0d uf=%0b, required pc=%h cnt=%0d uf=0",
                 i, pc_out, ras_count, ras_underflow, exp_ret[i], 3 - i);
      end
    end
    apply(1'b1, RET, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h18 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
      miscompares++;
      $display("FAIL underflow: pc=%h uf=%0b cnt=%0d, required pc=00000018 uf=1 cnt=0",
               pc_out, ras_underflow, ras_count);
    end
    apply(1'b1, SEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h1C || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_pulse_end: pc=%h uf=%0b, required pc=0000001c uf=0", pc_out, ras_underflow);
    end
  endtask

  task automatic test_return_link;
    apply(1'b0, SEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (ras_count !== 3'd0 || pc_out !== 32'h1C) begin
      miscompares++;
      $display("FAIL clear_stalled: cnt=%0d pc=%h, required cnt=0 pc=0000001c", ras_count, pc_out);
    end
    redirect_to(32'h1C);
    apply(1'b1, TGT, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
    redirect_to(32'h7C);
    apply(1'b1, TGT, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
    // Redirect while link/RETURN are asserted must leave the RAS untouched.
    apply(1'b1, RET, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0);
    vectors++;
    if (pc_out !== 32'h300 || ras_count !== 3'd2 || ras_top !== 32'h80) begin
      miscompares++;
      $display("FAIL redirect_ras_hold: pc=%h cnt=%0d top=%h, required pc=00000300 cnt=2 top=00000080",
               pc_out, ras_count, ras_top);
    end
    apply(1'b1, RET, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h80 || ras_top !== 32'h304 || ras_count !== 3'd2) begin
      miscompares++;
      $display("FAIL ret_link: pc=%h top=%h cnt=%0d, required pc=00000080 top=00000304 cnt=2",
               pc_out, ras_top, ras_count);
    end
    apply(1'b1, RET, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h304 || ras_count !== 3'd1 || ras_top !== 32'h20) begin
      miscompares++;
      $display("FAIL ret_after_replace: pc=%h cnt=%0d top=%h, required pc=00000304 cnt=1 top=00000020",
               pc_out, ras_count, ras_top);
    end
    apply(1'b1, RET, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h20 || ras_count !== 3'd0 || ras_top !== 32'h0) begin
      miscompares++;
      $display("FAIL ret_oldest: pc=%h cnt=%0d top=%h, required pc=00000020 cnt=0 top=0",
               pc_out, ras_count, ras_top);
    end
    apply(1'b1, RET, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h24 || ras_underflow !== 1'b1 || ras_count !== 3'd1 || ras_top !== 32'h24) begin
      miscompares++;
      $display("FAIL empty_ret_link: pc=%h uf=%0b cnt=%0d top=%h, required pc=00000024 uf=1 cnt=1 top=00000024",
               pc_out, ras_underflow, ras_count, ras_top);
    end
    // Clear wins over simultaneous push/pop.
    apply(1'b1, RET, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (pc_out !== 32'h24 || ras_count !== 3'd0 || ras_top !== 32'h0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_precedence: pc=%h cnt=%0d top=%h uf=%0b, required pc=00000024 cnt=0 top=0 uf=0",
               pc_out, ras_count, ras_top, ras_underflow);
    end
    apply(1'b1, TGT, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h600 || ras_count !== 3'd1 || ras_top !== 32'h28) begin
      miscompares++;
      $display("FAIL push_after_clear: pc=%h cnt=%0d top=%h, required pc=00000600 cnt=1 top=00000028",
               pc_out, ras_count, ras_top);
    end
  endtask

  task automatic test_wrap_and_reset;
    redirect_to(32'hFFFF_FFFC);
    vectors++;
    if (pc_plus !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc_plus: got %h, required 00000000", pc_plus);
    end
    apply(1'b1, SEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (pc_out !== 32'h0 || pc_plus !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_seq: pc=%h plus=%h, required pc=0 plus=00000004", pc_out, pc_plus);
    end
    apply(1'b1, TGT, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (ras_count !== 3'd2 || ras_top !== 32'h4) begin
      miscompares++;
      $display("FAIL pre_reset_push: cnt=%0d top=%h, required cnt=2 top=00000004", ras_count, ras_top);
    end
    RST = 1'b1;
    apply(1'b1, RET, 32'h800, 1'b1, 1'b1, 32'h900, 1'b0);
    RST = 1'b0;
    vectors++;
    if (pc_out !== 32'h0 || ras_count !== 3'd0 || ras_top !== 32'h0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midop: pc=%h cnt=%0d top=%h uf=%0b, required pc=0 cnt=0 top=0 uf=0",
               pc_out, ras_count, ras_top, ras_underflow);
    end
  endtask

  initial begin
    RST = 1'b1; pcWEN = 1'b0; next_sel = SEQ; target = '0; link = 1'b0;
    redirect = 1'b0; redirect_pc = '0; ras_clear = 1'b0;
    test_reset;
    test_stall_redirect;
    test_call_return;
    test_ras_overflow;
    test_return_link;
    test_wrap_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
